// File: rtl/demux1t2_64_buf_if.sv
// Handshake bundle for demux1t2_64_buf: one producer side, two consumer channels,
// plus the per-channel delivery counters and the current steering target.
interface demux1t2_64_buf_if #(
  parameter int WIDTH = 64,
  parameter int CNT_W = 16
);
  logic [WIDTH-1:0] I;
  logic             in_valid;
  logic             sel;
  logic             in_ready;
  logic [WIDTH-1:0] o0;
  logic             o0_valid;
  logic             o0_ready;
  logic [WIDTH-1:0] o1;
  logic             o1_valid;
  logic             o1_ready;
  logic [CNT_W-1:0] cnt0;
  logic [CNT_W-1:0] cnt1;
  logic             tgt;

  modport slave (
    input  I, in_valid, sel, o0_ready, o1_ready,
    output in_ready, o0, o0_valid, o1, o1_valid, cnt0, cnt1, tgt
  );

  modport master (
    output I, in_valid, sel, o0_ready, o1_ready,
    input  in_ready, o0, o0_valid, o1, o1_valid, cnt0, cnt1, tgt
  );
endinterface

// File: rtl/demux1t2_64_buf.sv
// 1-to-2 demultiplexer with a one-word holding register per output channel,
// steering by sel (MODE=0) or an accept-driven ping-pong toggle (MODE=1).
module demux1t2_64_buf #(
  parameter int WIDTH = 64,
  parameter int MODE  = 0,
  parameter int CNT_W = 16
) (
  input logic                  clk,
  input logic                  rst,
  demux1t2_64_buf_if.slave     bus
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } ch_state_e;

  localparam logic             PING_PONG = (MODE == 32'sd1);
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

  ch_state_e        st0_q, st0_d;
  ch_state_e        st1_q, st1_d;
  logic [WIDTH-1:0] dat0_q, dat0_d;
  logic [WIDTH-1:0] dat1_q, dat1_d;
  logic [CNT_W-1:0] cnt0_q, cnt0_d;
  logic [CNT_W-1:0] cnt1_q, cnt1_d;
  logic             tog_q, tog_d;

  logic tgt_s;
  logic in_ready_s;
  logic acc_s;
  logic ld0_s, ld1_s;
  logic drain0_s, drain1_s;

  // A load wins over a drain, so a same-cycle drain+load keeps the channel FULL.
  function automatic ch_state_e ch_next(ch_state_e cur, logic ld, logic drain);
    ch_state_e nxt;
    case (cur)
      EMPTY:   nxt = ld ? FULL : EMPTY;
      FULL:    nxt = ld ? FULL : (drain ? EMPTY : FULL);
      default: nxt = EMPTY;
    endcase
    return nxt;
  endfunction

  always_comb begin
    tgt_s    = 1'b0;
    drain0_s = (st0_q == FULL) & bus.o0_ready;
    drain1_s = (st1_q == FULL) & bus.o1_ready;

    if (PING_PONG) begin
      tgt_s = tog_q;
    end else begin
      tgt_s = bus.sel;
    end

    // Ready looks only at the targeted channel, never at in_valid.
    if (tgt_s) begin
      in_ready_s = (st1_q == EMPTY) | bus.o1_ready;
    end else begin
      in_ready_s = (st0_q == EMPTY) | bus.o0_ready;
    end

    acc_s = bus.in_valid & in_ready_s;
    ld0_s = acc_s & ~tgt_s;
    ld1_s = acc_s & tgt_s;

    st0_d  = ch_next(st0_q, ld0_s, drain0_s);
    st1_d  = ch_next(st1_q, ld1_s, drain1_s);
    dat0_d = ld0_s ? bus.I : dat0_q;
    dat1_d = ld1_s ? bus.I : dat1_q;

    if (drain0_s && (cnt0_q != CNT_MAX)) begin
      cnt0_d = cnt0_q + CNT_ONE;
    end else begin
      cnt0_d = cnt0_q;
    end

    if (drain1_s && (cnt1_q != CNT_MAX)) begin
      cnt1_d = cnt1_q + CNT_ONE;
    end else begin
      cnt1_d = cnt1_q;
    end

    if (PING_PONG && acc_s) begin
      tog_d = ~tog_q;
    end else begin
      tog_d = tog_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st0_q  <= EMPTY;
      st1_q  <= EMPTY;
      dat0_q <= {WIDTH{1'b0}};
      dat1_q <= {WIDTH{1'b0}};
      cnt0_q <= {CNT_W{1'b0}};
      cnt1_q <= {CNT_W{1'b0}};
      tog_q  <= 1'b0;
    end else begin
      st0_q  <= st0_d;
      st1_q  <= st1_d;
      dat0_q <= dat0_d;
      dat1_q <= dat1_d;
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
      tog_q  <= tog_d;
    end
  end

  assign bus.in_ready = in_ready_s;
  assign bus.tgt      = tgt_s;
  assign bus.o0       = dat0_q;
  assign bus.o1       = dat1_q;
  assign bus.o0_valid = (st0_q == FULL);
  assign bus.o1_valid = (st1_q == FULL);
  assign bus.cnt0     = cnt0_q;
  assign bus.cnt1     = cnt1_q;

endmodule

// File: tb/tb_demux1t2_64_buf.sv
// Scoreboard bench: stimulus pushes expected words per channel, a negedge monitor
// pops them whenever a channel hands a word to its consumer.
module tb_demux1t2_64_buf;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  demux1t2_64_buf_if #(.WIDTH(64), .CNT_W(16)) ia ();
  demux1t2_64_buf_if #(.WIDTH(64), .CNT_W(16)) ib ();
  demux1t2_64_buf_if #(.WIDTH(64), .CNT_W(4))  ic ();

  demux1t2_64_buf #(.WIDTH(64), .MODE(0), .CNT_W(16)) u_sel  (.clk(clk), .rst(rst), .bus(ia.slave));
  demux1t2_64_buf #(.WIDTH(64), .MODE(1), .CNT_W(16)) u_ping (.clk(clk), .rst(rst), .bus(ib.slave));
  demux1t2_64_buf #(.WIDTH(64), .MODE(0), .CNT_W(4))  u_sat  (.clk(clk), .rst(rst), .bus(ic.slave));

  int n_tests = 0;
  int n_fail  = 0;
  logic [63:0] exp_q [6][$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic mon(input int k, input logic v, input logic r, input logic [63:0] d);
    logic [63:0] e;
    if (v && r) begin
      if (exp_q[k].size() == 0) begin
        chk($sformatf("unexpected_word_ch%0d", k), d, 64'hx);
      end else begin
        e = exp_q[k].pop_front();
        chk($sformatf("data_ch%0d", k), d, e);
      end
    end
  endtask

  // Monitor: every delivered word is matched against the scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      mon(0, ia.o0_valid, ia.o0_ready, ia.o0);
      mon(1, ia.o1_valid, ia.o1_ready, ia.o1);
      mon(2, ib.o0_valid, ib.o0_ready, ib.o0);
      mon(3, ib.o1_valid, ib.o1_ready, ib.o1);
      mon(4, ic.o0_valid, ic.o0_ready, ic.o0);
      mon(5, ic.o1_valid, ic.o1_ready, ic.o1);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  logic [63:0] w1, w2;
  logic [63:0] pp [4];

  initial begin
    ia.I = 64'd0; ia.in_valid = 1'b0; ia.sel = 1'b0; ia.o0_ready = 1'b0; ia.o1_ready = 1'b0;
    ib.I = 64'd0; ib.in_valid = 1'b0; ib.sel = 1'b0; ib.o0_ready = 1'b0; ib.o1_ready = 1'b0;
    ic.I = 64'd0; ic.in_valid = 1'b0; ic.sel = 1'b0; ic.o0_ready = 1'b0; ic.o1_ready = 1'b0;
    w1 = 64'h1111_2222_3333_4444;
    w2 = 64'h5555_6666_7777_8888;
    pp[0] = 64'h0000_0000_0000_00AA;
    pp[1] = 64'h0000_0000_0000_00BB;
    pp[2] = 64'h0000_0000_0000_00CC;
    pp[3] = 64'h0000_0000_0000_00DD;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_o0_valid", {63'd0, ia.o0_valid}, 64'd0);
    chk("rst_o1_valid", {63'd0, ia.o1_valid}, 64'd0);
    chk("rst_cnt0", {48'd0, ia.cnt0}, 64'd0);
    chk("rst_o0", ia.o0, 64'd0);
    smp();
    rst = 1'b0;

    // MODE=0 steering to channel 1
    step();
    ia.sel = 1'b1; ia.I = 64'hDEAD_BEEF_0123_4567; ia.in_valid = 1'b1;
    exp_q[1].push_back(64'hDEAD_BEEF_0123_4567);
    smp();
    chk("steer_in_ready_empty", {63'd0, ia.in_ready}, 64'd1);
    step();
    ia.in_valid = 1'b0;
    smp();
    chk("steer_o1", ia.o1, 64'hDEAD_BEEF_0123_4567);
    chk("steer_o1_valid", {63'd0, ia.o1_valid}, 64'd1);
    chk("steer_o0_valid", {63'd0, ia.o0_valid}, 64'd0);
    chk("steer_in_ready_sel1", {63'd0, ia.in_ready}, 64'd0);
    step();
    ia.sel = 1'b0; ia.o1_ready = 1'b1;
    smp();
    chk("steer_in_ready_sel0", {63'd0, ia.in_ready}, 64'd1);
    step();
    ia.o1_ready = 1'b0;
    smp();
    chk("steer_cnt1", {48'd0, ia.cnt1}, 64'd1);
    chk("steer_o1_drained", {63'd0, ia.o1_valid}, 64'd0);

    // Back-pressure hold on channel 0
    step();
    ia.I = w1; ia.in_valid = 1'b1;
    exp_q[0].push_back(w1);
    step();
    ia.I = w2;
    for (int i = 0; i < 5; i++) begin
      smp();
      chk("bp_o0_hold", ia.o0, w1);
      chk("bp_in_ready", {63'd0, ia.in_ready}, 64'd0);
      step();
    end
    ia.o0_ready = 1'b1;
    exp_q[0].push_back(w2);
    smp();
    chk("bp_release_ready", {63'd0, ia.in_ready}, 64'd1);
    step();
    ia.in_valid = 1'b0; ia.o0_ready = 1'b0;
    smp();
    chk("bp_o0_new", ia.o0, w2);
    chk("bp_o0_valid", {63'd0, ia.o0_valid}, 64'd1);
    chk("bp_cnt0", {48'd0, ia.cnt0}, 64'd1);
    step();
    ia.o0_ready = 1'b1;
    smp();
    step();

    // Streaming 1..8 on channel 0
    for (int i = 1; i <= 8; i++) begin
      ia.I = 64'(i); ia.in_valid = 1'b1;
      exp_q[0].push_back(64'(i));
      smp();
      chk("stream_in_ready", {63'd0, ia.in_ready}, 64'd1);
      if (i > 1) chk("stream_o0", ia.o0, 64'(i - 1));
      step();
    end
    ia.in_valid = 1'b0;
    smp();
    step();
    ia.o0_ready = 1'b0;
    smp();
    chk("stream_cnt0", {48'd0, ia.cnt0}, 64'd10);

    // Ping-pong
    step();
    ib.o0_ready = 1'b1; ib.o1_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      ib.I = pp[i]; ib.in_valid = 1'b1;
      exp_q[2 + (i % 2)].push_back(pp[i]);
      smp();
      chk("pp_tgt", {63'd0, ib.tgt}, 64'(i % 2));
      chk("pp_in_ready", {63'd0, ib.in_ready}, 64'd1);
      step();
    end
    ib.in_valid = 1'b0;
    smp();
    step();
    smp();
    chk("pp_cnt0", {48'd0, ib.cnt0}, 64'd2);
    chk("pp_cnt1", {48'd0, ib.cnt1}, 64'd2);
    chk("pp_tgt_wrap", {63'd0, ib.tgt}, 64'd0);
    step();
    ib.o1_ready = 1'b0;
    ib.I = 64'hE; ib.in_valid = 1'b1;
    exp_q[2].push_back(64'hE);
    smp();
    step();
    ib.I = 64'hF;
    exp_q[3].push_back(64'hF);
    smp();
    step();
    ib.I = 64'h6; ib.o0_ready = 1'b0;
    exp_q[2].push_back(64'h6);
    smp();
    step();
    ib.I = 64'h7;
    smp();
    chk("pp_stall_tgt", {63'd0, ib.tgt}, 64'd1);
    chk("pp_stall_in_ready", {63'd0, ib.in_ready}, 64'd0);
    chk("pp_stall_o1", ib.o1, 64'hF);
    step();
    smp();
    chk("pp_stall_in_ready2", {63'd0, ib.in_ready}, 64'd0);
    chk("pp_stall_o0", ib.o0, 64'h6);
    ib.in_valid = 1'b0;

    // Asynchronous reset between edges with both channels full
    @(posedge clk);
    #3;
    chk("pre_rst_both_full", {62'd0, ib.o0_valid, ib.o1_valid}, 64'd3);
    rst = 1'b1;
    #1;
    chk("arst_o0_valid", {63'd0, ib.o0_valid}, 64'd0);
    chk("arst_o1_valid", {63'd0, ib.o1_valid}, 64'd0);
    chk("arst_cnt0", {48'd0, ib.cnt0}, 64'd0);
    chk("arst_cnt1", {48'd0, ib.cnt1}, 64'd0);
    chk("arst_o0", ib.o0, 64'd0);
    chk("arst_o1", ib.o1, 64'd0);
    chk("arst_tgt", {63'd0, ib.tgt}, 64'd0);
    for (int k = 0; k < 6; k++) exp_q[k].delete();
    step();
    rst = 1'b0;

    // Counter saturation with CNT_W=4
    step();
    ic.sel = 1'b1; ic.o1_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      ic.I = 64'(i + 100); ic.in_valid = 1'b1;
      exp_q[5].push_back(64'(i + 100));
      smp();
      step();
    end
    ic.in_valid = 1'b0;
    smp();
    step();
    smp();
    chk("sat_cnt1", {60'd0, ic.cnt1}, 64'd15);
    chk("sat_cnt0", {60'd0, ic.cnt0}, 64'd0);

    for (int k = 0; k < 6; k++) begin
      chk($sformatf("leftover_ch%0d", k), 64'(exp_q[k].size()), 64'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/demux1t2_64_buf.md
Name: demux1t2_64_buf

Overview:
- 64-bit 1-to-2 demultiplexer with a one-word holding register per output channel and valid/ready handshakes on every side.
- Steers each accepted input word to channel 0 or channel 1. Steering comes from the `sel` input, or from an internal ping-pong toggle when `MODE`=1.
- Sits in the datapath where a single producer (ALU/memory result bus) feeds two consumers (e.g. register-file write port and store buffer).
- Also keeps per-channel transfer counters for debug and visibility.

Parameters:
- WIDTH, 64, data width of the input and both outputs.
- MODE, 0, steering mode: 0 = steer by `sel`; 1 = alternate channels, starting at channel 0 after reset.
- CNT_W, 16, width of each per-channel transfer counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- I  input  WIDTH  input data word.
- in_valid  input  1  `I` is valid this cycle.
- sel  input  1  target channel when `MODE`=0 (0 → o0, 1 → o1); ignored when `MODE`=1.
- in_ready  output  1  block accepts `I` this cycle.
- o0  output  WIDTH  channel 0 data.
- o0_valid  output  1  `o0` holds an undelivered word.
- o0_ready  input  1  channel 0 consumer accepts.
- o1  output  WIDTH  channel 1 data.
- o1_valid  output  1  `o1` holds an undelivered word.
- o1_ready  input  1  channel 1 consumer accepts.
- cnt0  output  CNT_W  words delivered on channel 0, saturating.
- cnt1  output  CNT_W  words delivered on channel 1, saturating.
- tgt  output  1  channel the next accepted word will go to.

Behaviour:
- Reset (async, rst=1):
  - o0, o1 = 0; o0_valid, o1_valid = 0; cnt0, cnt1 = 0; ping-pong toggle = 0.
  - All registers update only on rising clk while rst=0.
- Target select:
  - `tgt` = `sel` when `MODE`=0, otherwise `tgt` = the toggle.
  - Combinational; valid in the same cycle.
- Per-channel state machine (channel k), two states:
  - EMPTY (ok_valid=0) or FULL (ok_valid=1).
  - EMPTY → FULL on accept with tgt=k.
  - FULL → EMPTY on ok_valid & ok_ready with no new accept to k.
  - FULL → FULL on simultaneous drain and accept to k: the register loads the new word and ok_valid stays 1.
- Ready:
  - in_ready = ~ok_valid | ok_ready, for k = `tgt`.
  - in_ready is combinational from `tgt`, ok_valid and ok_ready. It has no path from in_valid.
- Accept:
  - Accept = in_valid & in_ready.
  - On accept, `I` is captured into the target register and appears at ok with ok_valid=1 on the next cycle (latency 1).
  - The non-target channel is unaffected, and can drain in the same cycle.
- Output stability:
  - While ok_valid=1 and ok_ready=0, ok is held stable.
  - While ok_valid=0, ok retains its last value (not cleared).
- Toggle (`MODE`=1):
  - Flips on each accept only. A stalled target blocks input; the block does not skip to the other channel.
- Counters:
  - cntk increments by 1 on each ok_valid & ok_ready.
  - Saturates at 2^CNT_W−1 with no wrap.
- Throughput: sustains 1 word/cycle to a channel whose consumer holds ok_ready=1.
- Reset mid-operation: buffered words are discarded, valids drop immediately (asynchronous), and counters and the toggle clear.
- Simultaneous events: when both channels drain and one is loaded in the same cycle, the drain and the load are handled independently per channel.

Test Plan:
- `MODE`=0 steering:
  - Stimulus: sel=1, I=64'hDEAD_BEEF_0123_4567, in_valid=1 for 1 cycle, o1_ready=0.
  - Response: next cycle o1=64'hDEAD_BEEF_0123_4567, o1_valid=1, o0_valid=0. in_ready=0 while sel=1; in_ready=1 when sel=0.
- Back-pressure hold:
  - Stimulus: o0 full, o0_ready=0 for 5 cycles with a new I presented (sel=0).
  - Response: o0 unchanged, in_ready=0. Then assert o0_ready=1: the new word is loaded in the same cycle, o0_valid stays 1, cnt0 increments by 1.
- Streaming:
  - Stimulus: 8 consecutive words 1..8 to channel 0, o0_ready=1 throughout.
  - Response: o0 shows 1..8 on consecutive cycles, in_ready=1 every cycle, cnt0=8.
- Ping-pong (`MODE`=1):
  - Stimulus: words A,B,C,D, both readies=1.
  - Response: A→o0, B→o1, C→o0, D→o1; cnt0=2, cnt1=2. Then hold o1_ready=0 with o1 full: after the next word to o0, in_ready=0 and tgt=1.
- Counter saturation:
  - Stimulus: CNT_W=4, 20 transfers on channel 1.
  - Response: cnt1=15, no wrap.
- Async reset mid-transfer:
  - Stimulus: both channels full, assert rst between clock edges.
  - Response: o0_valid=o1_valid=0 and cnt0=cnt1=0 immediately, before the next edge; o0=o1=0; tgt=0 in `MODE`=1.
